// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 16-bit interval timer with prescaler, sticky
// done flag and optional auto-reload. Four word registers at BASE..BASE+3:
// CTRL, LOAD, COUNT (read-only) and STATUS.
module mmio_timer #(
  parameter logic [8:0] BASE     = 9'h180,
  parameter int         PRESCALE = 50000,
  parameter int         PW       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        rd_hit,
  output logic        done
);

  localparam logic [1:0]    CMD_READ  = 2'b01;
  localparam logic [1:0]    CMD_WRITE = 2'b10;
  localparam logic [1:0]    REG_CTRL   = 2'd0;
  localparam logic [1:0]    REG_LOAD   = 2'd1;
  localparam logic [1:0]    REG_COUNT  = 2'd2;
  localparam logic [1:0]    REG_STATUS = 2'd3;
  localparam logic [PW-1:0] PS_LAST   = PW'(PRESCALE - 1);

  logic          en_q, en_d;
  logic          auto_q, auto_d;
  logic [15:0]   load_q, load_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic       hit;
  logic       wr_hit;
  logic [1:0] reg_idx;
  logic       tick;

  // Address decode and prescaler terminal-count detection
  always_comb begin
    hit     = (mem_addr[8:2] == BASE[8:2]);
    reg_idx = mem_addr[1:0];
    wr_hit  = hit && (mem_cmd == CMD_WRITE);
    rd_hit  = hit && (mem_cmd == CMD_READ);
    tick    = en_q && (presc_q == PS_LAST);
  end

  // Combinational read mux; zero whenever the read is not for this window
  always_comb begin
    read_data = 16'h0000;
    if (rd_hit) begin
      case (reg_idx)
        REG_CTRL:   read_data = {14'b0, auto_q, en_q};
        REG_LOAD:   read_data = load_q;
        REG_COUNT:  read_data = count_q;
        REG_STATUS: read_data = {15'b0, done_q};
        default:    read_data = 16'h0000;
      endcase
    end
  end

  // Next-state: prescaler and tick effects first, then CPU writes override
  // the fields they touch. A STATUS clear is applied before the tick so an
  // expiry in the same cycle keeps done set.
  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = done_q;

    if (en_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (wr_hit && (reg_idx == REG_STATUS) && write_data[0]) begin
      done_d = 1'b0;
    end

    if (tick) begin
      if (count_q > 16'd1) begin
        count_d = count_q - 16'd1;
      end else begin
        // count is 1 (normal expiry) or 0 (timer loaded with zero)
        done_d = 1'b1;
        if (auto_q && (count_q == 16'd1)) begin
          count_d = load_q;
        end else begin
          count_d = 16'd0;
          if (!auto_q) begin
            en_d = 1'b0;
          end
        end
      end
    end

    if (wr_hit && (reg_idx == REG_CTRL)) begin
      en_d    = write_data[0];
      auto_d  = write_data[1];
      presc_d = '0;
    end

    if (wr_hit && (reg_idx == REG_LOAD)) begin
      load_d  = write_data;
      count_d = write_data;
      presc_d = '0;
    end
  end

  // State registers with synchronous reset; reset masks any bus write
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      load_q  <= 16'd0;
      count_q <= 16'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      auto_q  <= auto_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule
